// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
// Helpers work on a 64-bit / 8-lane superset; callers truncate to N.
package mem_pkg;

    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_L = MAX_N / 8;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Low offset bits that must be zero for an aligned access of this size
    function automatic logic [2:0] size_mask(input mem_size_t s);
        case (s)
            MEM_B:   size_mask = 3'd0;
            MEM_H:   size_mask = 3'd1;
            MEM_W:   size_mask = 3'd3;
            default: size_mask = 3'd7;
        endcase
    endfunction

    // Byte enables for an access of size s starting at lane off
    function automatic logic [MAX_L-1:0] be_gen(input mem_size_t s, input logic [2:0] off);
        case (s)
            MEM_B:   be_gen = 8'h01 << off;
            MEM_H:   be_gen = 8'h03 << off;
            MEM_W:   be_gen = 8'h0F << off;
            default: be_gen = 8'hFF;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane group
    function automatic logic [MAX_N-1:0] store_align(input mem_size_t s, input logic [MAX_N-1:0] d);
        case (s)
            MEM_B:   store_align = {8{d[7:0]}};
            MEM_H:   store_align = {4{d[15:0]}};
            MEM_W:   store_align = {2{d[31:0]}};
            default: store_align = d;
        endcase
    endfunction

    // Pick the addressed lanes out of the read word and extend them
    function automatic logic [MAX_N-1:0] load_extract(input mem_size_t s, input logic uns,
                                                      input logic [2:0] off,
                                                      input logic [MAX_N-1:0] rd);
        logic [MAX_N-1:0] sh;
        sh = rd >> {off, 3'b000};
        case (s)
            MEM_B:   load_extract = {{56{~uns & sh[7]}},  sh[7:0]};
            MEM_H:   load_extract = {{48{~uns & sh[15]}}, sh[15:0]};
            MEM_W:   load_extract = {{32{~uns & sh[31]}}, sh[31:0]};
            default: load_extract = sh;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_fsm.sv
// Request/response handshake FSM for the MEM stage: holds the memory
// request payload, captures read data and generates the pipeline stall.
module lsu_fsm
    import mem_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned A   = 32,
    parameter int unsigned L   = N / 8,
    parameter int unsigned OFF = $clog2(L)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           mem_req_i,
    input  logic           exc_req_i,
    input  logic           we_i,
    input  logic [A-1:0]   addr_i,
    input  logic [L-1:0]   be_i,
    input  logic [N-1:0]   wdata_i,
    input  mem_size_t      size_i,
    input  logic           uns_i,
    input  logic [OFF-1:0] off_i,
    input  logic           mem_ready_i,
    input  logic           valid_i,
    input  logic [N-1:0]   rdata_i,
    output logic           proc_req_o,
    output logic           we_o,
    output logic [A-1:0]   addr_o,
    output logic [N-1:0]   wdata_o,
    output logic [L-1:0]   be_o,
    output logic           stall_o,
    output logic           exc_o,
    output logic           ld_ok_o,
    output logic [N-1:0]   rdata_o,
    output mem_size_t      size_o,
    output logic           uns_o,
    output logic [OFF-1:0] off_o
);

    lsu_state_t     state_q;
    logic           proc_req_q;
    logic           we_q;
    logic [A-1:0]   addr_q;
    logic [N-1:0]   wdata_q;
    logic [L-1:0]   be_q;
    logic           exc_q;
    logic           ld_ok_q;
    logic [N-1:0]   rdata_q;
    mem_size_t      size_q;
    logic           uns_q;
    logic [OFF-1:0] off_q;

    // Handshake state machine with request payload and load-data capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            proc_req_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            exc_q      <= 1'b0;
            ld_ok_q    <= 1'b0;
            rdata_q    <= '0;
            size_q     <= MEM_B;
            uns_q      <= 1'b0;
            off_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_req_i) begin
                        ld_ok_q <= 1'b0;
                        if (exc_req_i) begin
                            exc_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            exc_q      <= 1'b0;
                            proc_req_q <= 1'b1;
                            we_q       <= we_i;
                            addr_q     <= addr_i;
                            wdata_q    <= wdata_i;
                            be_q       <= be_i;
                            size_q     <= size_i;
                            uns_q      <= uns_i;
                            off_q      <= off_i;
                            state_q    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        proc_req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= S_DONE;
                        end else if (valid_i) begin
                            rdata_q <= rdata_i;
                            ld_ok_q <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (valid_i) begin
                        rdata_q <= rdata_i;
                        ld_ok_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    exc_q   <= 1'b0;
                    ld_ok_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stall rises with the request in IDLE and releases only in DONE
    assign stall_o = ((state_q == S_IDLE) && mem_req_i) ||
                     (state_q == S_REQ) || (state_q == S_WAIT);

    assign proc_req_o = proc_req_q;
    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign be_o       = be_q;
    assign exc_o      = exc_q;
    assign ld_ok_o    = ld_ok_q;
    assign rdata_o    = rdata_q;
    assign size_o     = size_q;
    assign uns_o      = uns_q;
    assign off_o      = off_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: byte-lane address/strobe/data shaping, handshake FSM
// instance and MEM/WB pipeline registers with extended load data.
// Optional: MEM_MISALIGN_EXC_EN turns misaligned accesses into a flagged
// no-op instead of truncating the low address bits.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned A      = 32,
    parameter int unsigned CWWB_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_en,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [CWWB_W-1:0] cwWB_in,
    input  logic [N-1:0]      ALUres,
    input  logic [N-1:0]      wrData_in,
    input  logic [N-1:0]      NPCin,
    input  logic [N-1:0]      IMMin,
    input  logic [4:0]        Rdest_in,
    input  logic              mem_ready,
    input  logic              valid,
    input  logic [N-1:0]      rdata,
    output logic              proc_req,
    output logic              we_out,
    output logic [A-1:0]      addr,
    output logic [N-1:0]      wdata,
    output logic [N/8-1:0]    be,
    output logic [N-1:0]      ALUout,
    output logic [N-1:0]      NPCout,
    output logic [N-1:0]      IMMout,
    output logic [N-1:0]      LDout,
    output logic [4:0]        Rdest_out,
    output logic [CWWB_W-1:0] cwWB,
    output logic              stallMem,
    output logic              misalign
);

    localparam int unsigned L   = N / 8;
    localparam int unsigned OFF = $clog2(L);

    mem_size_t      size_d;
    logic [2:0]     off_d;
    logic [2:0]     mask_d;
    logic [2:0]     off_al_d;
    logic [A-1:0]   addr_d;
    logic [L-1:0]   be_d;
    logic [N-1:0]   wdata_d;
    logic           exc_req_d;

    logic           exc;
    logic           ld_ok;
    logic [N-1:0]   rdata_q;
    mem_size_t      size_q;
    logic           uns_q;
    logic [OFF-1:0] off_q;
    logic [N-1:0]   ld_ext_d;
    logic           wb_en_d;

    // Lane offset, truncated to the access size for the request payload
    assign size_d   = mem_size_t'(mem_size);
    assign off_d    = 3'(ALUres[OFF-1:0]);
    assign mask_d   = size_mask(size_d);
    assign off_al_d = off_d & ~mask_d;
    assign addr_d   = A'(ALUres) & ~A'(L - 1);
    assign be_d     = L'(be_gen(size_d, off_al_d));
    assign wdata_d  = N'(store_align(size_d, 64'(wrData_in)));

`ifdef MEM_MISALIGN_EXC_EN
    // Misaligned or oversize accesses are flagged and never reach memory
    assign exc_req_d = ((off_d & mask_d) != 3'd0) || ((size_d == MEM_D) && (N == 32));
`else
    assign exc_req_d = 1'b0;
`endif

    lsu_fsm #(
        .N   (N),
        .A   (A),
        .L   (L),
        .OFF (OFF)
    ) u_fsm (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_req_i   (mem_req),
        .exc_req_i   (exc_req_d),
        .we_i        (mem_we),
        .addr_i      (addr_d),
        .be_i        (be_d),
        .wdata_i     (wdata_d),
        .size_i      (size_d),
        .uns_i       (mem_unsigned),
        .off_i       (OFF'(off_al_d)),
        .mem_ready_i (mem_ready),
        .valid_i     (valid),
        .rdata_i     (rdata),
        .proc_req_o  (proc_req),
        .we_o        (we_out),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .be_o        (be),
        .stall_o     (stallMem),
        .exc_o       (exc),
        .ld_ok_o     (ld_ok),
        .rdata_o     (rdata_q),
        .size_o      (size_q),
        .uns_o       (uns_q),
        .off_o       (off_q)
    );

    assign ld_ext_d = N'(load_extract(size_q, uns_q, 3'(off_q), 64'(rdata_q)));
    assign wb_en_d  = pipe_en & ~stallMem;

    logic [N-1:0]      alu_q;
    logic [N-1:0]      npc_q;
    logic [N-1:0]      imm_q;
    logic [N-1:0]      ld_q;
    logic [4:0]        rdest_q;
    logic [CWWB_W-1:0] cw_q;

    // MEM/WB pipeline registers; a flagged access writes nothing back
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q   <= '0;
            npc_q   <= '0;
            imm_q   <= '0;
            ld_q    <= '0;
            rdest_q <= '0;
            cw_q    <= '0;
        end else if (wb_en_d) begin
            alu_q   <= ALUres;
            npc_q   <= NPCin;
            imm_q   <= IMMin;
            ld_q    <= ld_ok ? ld_ext_d : '0;
            rdest_q <= Rdest_in;
            cw_q    <= exc ? '0 : cwWB_in;
        end
    end

`ifdef MEM_MISALIGN_EXC_EN
    logic misalign_q;

    // Misalignment flag travels with the instruction into MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (wb_en_d) begin
            misalign_q <= exc;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign ALUout    = alu_q;
    assign NPCout    = npc_q;
    assign IMMout    = imm_q;
    assign LDout     = ld_q;
    assign Rdest_out = rdest_q;
    assign cwWB      = cw_q;

endmodule
